// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the IF port, DM port and memory-side signals of unified_mem_arbiter.
// slave is the arbiter's view; master is the view of the pipeline plus memory.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_valid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_gnt_o;
  logic              dm_valid_o;
  logic [DATA_W-1:0] dm_rdata_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  logic              busy_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_valid_o, if_rdata_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output dm_gnt_o, dm_valid_o, dm_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i,
    output busy_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_valid_o, if_rdata_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  dm_gnt_o, dm_valid_o, dm_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i,
    input  busy_o
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch (IF) and data (DM).
// Define ARB_FAIR_EN so IF wins a tie after DM has won a contested grant; default is strict DM priority.
//
// state | meaning
// IDLE  | sample requests; grant winner and strobe memory in the same cycle
// BUSY  | count down MEM_LAT; capture read data into owner's register on the last count
// RESP  | pulse owner's valid for one cycle, then return to IDLE
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 3
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  unified_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t            state;
  logic [3:0]        cnt;
  logic              owner_dm;
  logic              owner_we;
  logic              pick_dm;
  logic              pick_if;
  logic              if_valid_q;
  logic              dm_valid_q;
  logic              busy_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
`ifdef ARB_FAIR_EN
  logic              if_first;
`endif

  // Grant is combinational off IDLE; rst_n_i gating keeps the strobe quiet while reset is held.
  always_comb begin
    pick_dm = 1'b0;
    pick_if = 1'b0;
    if (rst_n_i && state == IDLE) begin
`ifdef ARB_FAIR_EN
      pick_dm = bus.dm_req_i && !(bus.if_req_i && if_first);
`else
      pick_dm = bus.dm_req_i;
`endif
      pick_if = bus.if_req_i && !pick_dm;
    end
  end

  assign bus.if_gnt_o    = pick_if;
  assign bus.dm_gnt_o    = pick_dm;
  assign bus.mem_en_o    = pick_dm | pick_if;
  assign bus.mem_we_o    = pick_dm & bus.dm_we_i;
  assign bus.mem_addr_o  = pick_dm ? bus.dm_addr_i : (pick_if ? bus.if_addr_i : '0);
  assign bus.mem_wdata_o = pick_dm ? bus.dm_wdata_i : '0;
  assign bus.if_valid_o  = if_valid_q;
  assign bus.dm_valid_o  = dm_valid_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.busy_o      = busy_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      cnt        <= '0;
      owner_dm   <= 1'b1;
      owner_we   <= 1'b0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_dm || pick_if) begin
            owner_dm <= pick_dm;
            owner_we <= pick_dm & bus.dm_we_i;
            cnt      <= LAT;
            busy_q   <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            // Writes still complete with a valid pulse but leave dm_rdata untouched.
            if (owner_dm) begin
              if (!owner_we) dm_rdata_q <= bus.mem_rdata_i;
              dm_valid_q <= 1'b1;
            end else begin
              if_rdata_q <= bus.mem_rdata_i;
              if_valid_q <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_FAIR_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                      if_first <= 1'b0;
    else if (pick_if)                  if_first <= 1'b0;
    else if (pick_dm && bus.if_req_i)  if_first <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios then random traffic on MEM_LAT=3 and MEM_LAT=1 instances,
// checked against a timestamp-based transaction model.
module tb_unified_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   sel   = 1'b0;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3();
  unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1();

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(b3.slave));
  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(b1.slave));

  wire          o_if_gnt   = sel ? b1.if_gnt_o    : b3.if_gnt_o;
  wire          o_dm_gnt   = sel ? b1.dm_gnt_o    : b3.dm_gnt_o;
  wire          o_if_valid = sel ? b1.if_valid_o  : b3.if_valid_o;
  wire          o_dm_valid = sel ? b1.dm_valid_o  : b3.dm_valid_o;
  wire [DW-1:0] o_if_rdata = sel ? b1.if_rdata_o  : b3.if_rdata_o;
  wire [DW-1:0] o_dm_rdata = sel ? b1.dm_rdata_o  : b3.dm_rdata_o;
  wire          o_busy     = sel ? b1.busy_o      : b3.busy_o;
  wire          m_en       = sel ? b1.mem_en_o    : b3.mem_en_o;
  wire          m_we       = sel ? b1.mem_we_o    : b3.mem_we_o;
  wire [AW-1:0] m_addr     = sel ? b1.mem_addr_o  : b3.mem_addr_o;
  wire [DW-1:0] m_wd       = sel ? b1.mem_wdata_o : b3.mem_wdata_o;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Memory: unwritten words read as hash(addr); read data appears for exactly one cycle,
  // MEM_LAT cycles after the strobe, with random garbage at all other times.
  bit [31:0]   mem [256];
  bit          wv  [256];
  logic [31:0] pd  [3];
  bit          pv  [3];
  bit [31:0]   junk;
  always @(posedge clk) begin
    if (m_en && m_we) begin
      mem[m_addr[9:2]] <= m_wd;
      wv[m_addr[9:2]]  <= 1'b1;
    end
    pd[0] <= wv[m_addr[9:2]] ? mem[m_addr[9:2]] : hash(m_addr);
    pv[0] <= m_en && !m_we;
    pd[1] <= pd[0];  pv[1] <= pv[0];
    pd[2] <= pd[1];  pv[2] <= pv[1];
    junk  <= $urandom;
  end
  assign b3.mem_rdata_i = pv[2] ? pd[2] : junk;
  assign b1.mem_rdata_i = pv[0] ? pd[0] : junk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          free_at = 0;
  int          t_grant = -10;
  int          t_valid = -10;
  bit          t_dm, t_we;
  logic [31:0] t_rd;
  logic [31:0] e_ird [2];
  logic [31:0] e_drd [2];
  bit          fair  [2];
  bit [31:0]   ref_mem [256];
  bit          ref_wv  [256];
  bit          d_pend = 0, d_we = 0, i_pend = 0;
  logic [31:0] d_addr = 0, d_wd = 0, i_addr = 0;
  int          seen_if_gnt, seen_dm_gnt, seen_if_valid, seen_dm_valid, start;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    b3.dm_req_i = d_pend && !sel;  b1.dm_req_i = d_pend && sel;
    b3.if_req_i = i_pend && !sel;  b1.if_req_i = i_pend && sel;
    b3.dm_we_i = d_we;      b1.dm_we_i = d_we;
    b3.dm_addr_i = d_addr;  b1.dm_addr_i = d_addr;
    b3.dm_wdata_i = d_wd;   b1.dm_wdata_i = d_wd;
    b3.if_addr_i = i_addr;  b1.if_addr_i = i_addr;
  endtask

  task automatic cycle();
    bit dwin, iwin;
    int lat;
    logic [31:0] ea;
    @(negedge clk);
    drive();
    #1;
    lat = sel ? 1 : 3;
    dwin = 0; iwin = 0; ea = '0;
    if (cyc >= free_at) begin
`ifdef ARB_FAIR_EN
      dwin = d_pend && !(i_pend && fair[sel]);
`else
      dwin = d_pend;
`endif
      iwin = i_pend && !dwin;
    end
    if (dwin || iwin) begin
`ifdef ARB_FAIR_EN
      if (dwin && i_pend) fair[sel] = 1;
      if (iwin) fair[sel] = 0;
`endif
      t_dm = dwin;
      t_we = dwin && d_we;
      ea   = dwin ? d_addr : i_addr;
      t_rd = ref_wv[ea[9:2]] ? ref_mem[ea[9:2]] : hash(ea);
      if (t_we) begin
        ref_mem[ea[9:2]] = d_wd;
        ref_wv[ea[9:2]]  = 1;
      end
      t_grant = cyc;
      t_valid = cyc + lat + 1;
      free_at = cyc + lat + 2;
    end
    if (cyc == t_valid && !t_we) begin
      if (t_dm) e_drd[sel] = t_rd;
      else      e_ird[sel] = t_rd;
    end
    if (o_if_gnt)   seen_if_gnt = cyc;
    if (o_dm_gnt)   seen_dm_gnt = cyc;
    if (o_if_valid) seen_if_valid = cyc;
    if (o_dm_valid) seen_dm_valid = cyc;
    chk("if_gnt",    32'(o_if_gnt),   32'(iwin));
    chk("dm_gnt",    32'(o_dm_gnt),   32'(dwin));
    chk("mem_en",    32'(m_en),       32'(dwin || iwin));
    chk("mem_we",    32'(m_we),       32'(dwin && d_we));
    chk("mem_addr",  m_addr,          ea);
    chk("mem_wdata", m_wd,            dwin ? d_wd : 32'h0);
    chk("if_valid",  32'(o_if_valid), 32'(cyc == t_valid && !t_dm));
    chk("dm_valid",  32'(o_dm_valid), 32'(cyc == t_valid && t_dm));
    chk("if_rdata",  o_if_rdata,      e_ird[sel]);
    chk("dm_rdata",  o_dm_rdata,      e_drd[sel]);
    chk("busy",      32'(o_busy),     32'(cyc > t_grant && cyc <= t_valid));
    if (dwin) d_pend = 0;
    if (iwin) i_pend = 0;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Requests are held high across reset to confirm the strobe and grants stay low.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    d_pend = 1; d_we = 1; d_addr = 32'h3C; d_wd = 32'hFFFF_FFFF;
    i_pend = 1; i_addr = 32'h44;
    drive();
    #1;
    chk("rst_if_gnt",   32'(o_if_gnt),   0);
    chk("rst_dm_gnt",   32'(o_dm_gnt),   0);
    chk("rst_mem_en",   32'(m_en),       0);
    chk("rst_mem_we",   32'(m_we),       0);
    chk("rst_mem_addr", m_addr,          0);
    chk("rst_mem_wd",   m_wd,            0);
    chk("rst_if_valid", 32'(o_if_valid), 0);
    chk("rst_dm_valid", 32'(o_dm_valid), 0);
    chk("rst_if_rdata", o_if_rdata,      0);
    chk("rst_dm_rdata", o_dm_rdata,      0);
    chk("rst_busy",     32'(o_busy),     0);
    @(negedge clk);
    rst_n = 1;
    d_pend = 0; i_pend = 0;
    drive();
    t_grant = -10; t_valid = -10; free_at = 0;
    for (int k = 0; k < 2; k++) begin
      e_ird[k] = '0; e_drd[k] = '0; fair[k] = 0;
    end
  endtask

  task automatic mark();
    start = cyc;
    seen_if_gnt = -1; seen_dm_gnt = -1; seen_if_valid = -1; seen_dm_valid = -1;
  endtask

  initial begin
    drive();
    do_reset();

    // Reset lands in BUSY of a DM read; nothing may surface afterwards.
    d_pend = 1; d_we = 0; d_addr = 32'h80;
    run(2);
    do_reset();
    run(6);
    mark();
    d_pend = 1; d_we = 0; d_addr = 32'h80;
    run(6);
    chk("p1_dm_valid_cyc", 32'(seen_dm_valid - start), 4);
    chk("p1_dm_rdata", o_dm_rdata, hash(32'h80));

    d_pend = 1; d_we = 1; d_addr = 32'h40; d_wd = 32'hDEADBEEF;
    run(6);
    mark();
    i_pend = 1; i_addr = 32'h40;
    run(6);
    chk("p2_if_gnt_cyc",   32'(seen_if_gnt - start),   0);
    chk("p2_if_valid_cyc", 32'(seen_if_valid - start), 4);
    chk("p2_if_rdata", o_if_rdata, 32'hDEADBEEF);

    mark();
    d_pend = 1; d_we = 1; d_addr = 32'h100; d_wd = 32'h12345678;
    run(6);
    chk("p3_dm_valid_cyc", 32'(seen_dm_valid - start), 4);
    chk("p3_dm_rdata_hold", o_dm_rdata, hash(32'h80));

    mark();
    d_pend = 1; d_we = 0; d_addr = 32'h100;
    i_pend = 1; i_addr = 32'h40;
    run(12);
    chk("p4_dm_gnt_cyc",   32'(seen_dm_gnt - start),   0);
    chk("p4_if_gnt_cyc",   32'(seen_if_gnt - start),   5);
    chk("p4_if_valid_cyc", 32'(seen_if_valid - start), 9);
    chk("p4_dm_rdata", o_dm_rdata, 32'h12345678);

    sel = 1;
    d_pend = 1; d_we = 1; d_addr = 32'h200; d_wd = 32'hA5A5A5A5;
    run(3);
    mark();
    d_pend = 1; d_we = 0; d_addr = 32'h200;
    i_pend = 1; i_addr = 32'h40;
    run(6);
    chk("p5_dm_valid_cyc", 32'(seen_dm_valid - start), 2);
    chk("p5_if_gnt_cyc",   32'(seen_if_gnt - start),   3);
    chk("p5_dm_rdata", o_dm_rdata, 32'hA5A5A5A5);
    chk("p5_if_rdata", o_if_rdata, 32'hDEADBEEF);

    for (int pass = 0; pass < 2; pass++) begin
      sel = (pass == 0) ? 1'b0 : 1'b1;
      for (int k = 0; k < 300 - 100 * pass; k++) begin
        if (!d_pend && $urandom_range(0, 2) == 0) begin
          d_pend = 1;
          d_we   = 1'($urandom_range(0, 1));
          d_addr = 32'($urandom_range(0, 63)) << 2;
          d_wd   = $urandom;
        end
        if (!i_pend && $urandom_range(0, 1) == 0) begin
          i_pend = 1;
          i_addr = 32'($urandom_range(0, 63)) << 2;
        end
        cycle();
      end
      while (d_pend || i_pend) cycle();
      run(6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
